// File: rtl/cv32e40p_ft_pkg.sv
// Shared types and default parameters for the fault-tolerant replica manager.
package cv32e40p_ft_pkg;

    typedef enum logic [1:0] {
        TMR     = 2'd0,
        DMR     = 2'd1,
        SIMPLEX = 2'd2,
        NONE    = 2'd3
    } ft_mode_e;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        SWITCH = 2'd2
    } ft_state_e;

    localparam int FT_N_UNITS_DEFAULT      = 4;
    localparam int FT_CNT_W_DEFAULT        = 4;
    localparam int FT_FAULT_THRESH_DEFAULT = 8;
    localparam int FT_DECAY_PERIOD_DEFAULT = 64;

endpackage

// File: rtl/cv32e40p_ft_healthy_pick.sv
// Maps the fault map onto the first three healthy replicas and the
// redundancy mode that their count allows.
module cv32e40p_ft_healthy_pick
    import cv32e40p_ft_pkg::*;
#(
    parameter int N_UNITS = FT_N_UNITS_DEFAULT,
    parameter int IDX_W   = $clog2(N_UNITS)
) (
    input  logic [N_UNITS-1:0] fault_i,
    output logic [3*IDX_W-1:0] sel_idx_o,
    output ft_mode_e           mode_o,
    output logic [N_UNITS-1:0] mask_o,
    output logic               none_left_o
);

    localparam int CW = $clog2(N_UNITS + 1);

    logic [CW-1:0]    healthy;
    logic [IDX_W-1:0] idx0, idx1, idx2;

    always_comb begin
        healthy = '0;
        idx0    = '0;
        idx1    = '0;
        idx2    = '0;
        mask_o  = '0;
        for (int k = 0; k < N_UNITS; k++) begin
            if (!fault_i[k]) begin
                if (healthy == CW'(0)) idx0 = IDX_W'(k);
                if (healthy == CW'(1)) idx1 = IDX_W'(k);
                if (healthy == CW'(2)) idx2 = IDX_W'(k);
                if (healthy < CW'(3))  mask_o[k] = 1'b1;
                healthy = healthy + 1'b1;
            end
        end
    end

    // Unused voter inputs mirror the last real replica so the voter sees agreement.
    always_comb begin
        mode_o      = NONE;
        sel_idx_o   = '0;
        none_left_o = 1'b0;
        if (healthy >= CW'(3)) begin
            mode_o    = TMR;
            sel_idx_o = {idx2, idx1, idx0};
        end else if (healthy == CW'(2)) begin
            mode_o    = DMR;
            sel_idx_o = {idx1, idx1, idx0};
        end else if (healthy == CW'(1)) begin
            mode_o    = SIMPLEX;
            sel_idx_o = {idx0, idx0, idx0};
        end else begin
            none_left_o = 1'b1;
        end
    end

endmodule

// File: rtl/cv32e40p_ft_replica_manager.sv
// Per-replica error tracking with leaky counters and drain-handshaked
// reconfiguration of the active replica set.
module cv32e40p_ft_replica_manager
    import cv32e40p_ft_pkg::*;
#(
    parameter int N_UNITS      = FT_N_UNITS_DEFAULT,
    parameter int CNT_W        = FT_CNT_W_DEFAULT,
    parameter int FAULT_THRESH = FT_FAULT_THRESH_DEFAULT,
    parameter int DECAY_PERIOD = FT_DECAY_PERIOD_DEFAULT,
    parameter int IDX_W        = $clog2(N_UNITS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               unit_used_i,
    input  logic               ex_idle_i,
    input  logic               vote_valid_i,
    input  logic [N_UNITS-1:0] vote_err_i,
    input  logic               clear_i,
    output logic [N_UNITS-1:0] clock_gate_o,
    output logic [3*IDX_W-1:0] sel_idx_o,
    output ft_mode_e           mode_o,
    output logic               stall_o,
    output logic [N_UNITS-1:0] perm_faulty_o,
    output logic               totally_defective_o
);

    localparam int DEC_W = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;

    logic [CNT_W-1:0]   cnt_q [N_UNITS];
    logic [CNT_W-1:0]   cnt_d [N_UNITS];
    logic [N_UNITS-1:0] fault_q, fault_d;
    logic [DEC_W-1:0]   decay_cnt_q, decay_cnt_d;
    ft_state_e          state_q, state_d;
    logic [N_UNITS-1:0] active_mask_q, active_mask_d;
    logic [3*IDX_W-1:0] sel_idx_q, sel_idx_d;
    ft_mode_e           mode_q, mode_d;

    logic [N_UNITS-1:0] hit;
    logic               clean_vote;
    logic               decay_tick;
    logic [3*IDX_W-1:0] tgt_sel;
    ft_mode_e           tgt_mode;
    logic [N_UNITS-1:0] tgt_mask;
    logic               none_left;

    cv32e40p_ft_healthy_pick #(
        .N_UNITS (N_UNITS),
        .IDX_W   (IDX_W)
    ) u_pick (
        .fault_i     (fault_q),
        .sel_idx_o   (tgt_sel),
        .mode_o      (tgt_mode),
        .mask_o      (tgt_mask),
        .none_left_o (none_left)
    );

    // Only disagreements of replicas currently feeding the voter count as errors.
    always_comb begin
        cnt_d       = cnt_q;
        fault_d     = fault_q;
        decay_cnt_d = decay_cnt_q;
        decay_tick  = 1'b0;
        hit         = vote_valid_i ? (vote_err_i & active_mask_q) : '0;
        clean_vote  = vote_valid_i && (hit == '0);

        if ((DECAY_PERIOD != 0) && clean_vote) begin
            if (decay_cnt_q == DEC_W'(DECAY_PERIOD - 1)) begin
                decay_cnt_d = '0;
                decay_tick  = 1'b1;
            end else begin
                decay_cnt_d = decay_cnt_q + 1'b1;
            end
        end

        for (int k = 0; k < N_UNITS; k++) begin
            if (!fault_q[k]) begin
                if (hit[k]) begin
                    if (cnt_q[k] != '1) cnt_d[k] = cnt_q[k] + 1'b1;
                end else if (decay_tick && (cnt_q[k] != '0)) begin
                    cnt_d[k] = cnt_q[k] - 1'b1;
                end
                if (cnt_d[k] == CNT_W'(FAULT_THRESH)) fault_d[k] = 1'b1;
            end
        end

        if (clear_i) begin
            for (int k = 0; k < N_UNITS; k++) cnt_d[k] = '0;
            fault_d     = '0;
            decay_cnt_d = '0;
        end
    end

    always_comb begin
        state_d       = state_q;
        active_mask_d = active_mask_q;
        sel_idx_d     = sel_idx_q;
        mode_d        = mode_q;
        stall_o       = 1'b0;
        case (state_q)
            RUN: begin
                if (tgt_mask != active_mask_q) state_d = DRAIN;
            end
            DRAIN: begin
                stall_o = 1'b1;
                if (ex_idle_i) state_d = SWITCH;
            end
            SWITCH: begin
                stall_o       = 1'b1;
                active_mask_d = tgt_mask;
                sel_idx_d     = tgt_sel;
                mode_d        = tgt_mode;
                state_d       = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < N_UNITS; k++) cnt_q[k] <= '0;
            fault_q       <= '0;
            decay_cnt_q   <= '0;
            state_q       <= RUN;
            active_mask_q <= N_UNITS'(7);
            sel_idx_q     <= {IDX_W'(2), IDX_W'(1), IDX_W'(0)};
            mode_q        <= TMR;
        end else begin
            cnt_q         <= cnt_d;
            fault_q       <= fault_d;
            decay_cnt_q   <= decay_cnt_d;
            state_q       <= state_d;
            active_mask_q <= active_mask_d;
            sel_idx_q     <= sel_idx_d;
            mode_q        <= mode_d;
        end
    end

    assign clock_gate_o        = unit_used_i ? active_mask_q : '0;
    assign sel_idx_o           = sel_idx_q;
    assign mode_o              = mode_q;
    assign perm_faulty_o       = fault_q;
    assign totally_defective_o = none_left;

endmodule

// File: tb/tb_cv32e40p_ft_replica_manager.sv
// Directed bench for the replica manager: fault declaration, drain handshake,
// degradation down to NONE, decay, clear and mid-reconfiguration events.
module tb_cv32e40p_ft_replica_manager;
    import cv32e40p_ft_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       unit_used_i;
    logic       ex_idle_i;
    logic       vote_valid_i;
    logic [3:0] vote_err_i;
    logic       clear_i;
    logic [3:0] clock_gate_o;
    logic [5:0] sel_idx_o;
    ft_mode_e   mode_o;
    logic       stall_o;
    logic [3:0] perm_faulty_o;
    logic       totally_defective_o;

    int tests_run    = 0;
    int tests_failed = 0;

    cv32e40p_ft_replica_manager #(
        .N_UNITS      (4),
        .CNT_W        (4),
        .FAULT_THRESH (8),
        .DECAY_PERIOD (4)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .unit_used_i         (unit_used_i),
        .ex_idle_i           (ex_idle_i),
        .vote_valid_i        (vote_valid_i),
        .vote_err_i          (vote_err_i),
        .clear_i             (clear_i),
        .clock_gate_o        (clock_gate_o),
        .sel_idx_o           (sel_idx_o),
        .mode_o              (mode_o),
        .stall_o             (stall_o),
        .perm_faulty_o       (perm_faulty_o),
        .totally_defective_o (totally_defective_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Presents n consecutive valid votes with the given error pattern.
    task automatic apply_stimulus(input logic [3:0] err, input int n);
        vote_valid_i = 1'b1;
        vote_err_i   = err;
        repeat (n) step();
        vote_valid_i = 1'b0;
        vote_err_i   = 4'b0000;
    endtask

    task automatic run_reconfig(input string tag);
        step();
        check_output({tag, "_drain_stall"}, 32'(stall_o), 32'd1);
        step();
        check_output({tag, "_switch_stall"}, 32'(stall_o), 32'd1);
        step();
        check_output({tag, "_run_stall"}, 32'(stall_o), 32'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        unit_used_i  = 1'b1;
        ex_idle_i    = 1'b1;
        vote_valid_i = 1'b0;
        vote_err_i   = 4'b0000;
        clear_i      = 1'b0;
        step();
        step();
        check_output("rst_gate", 32'(clock_gate_o), 32'h7);
        check_output("rst_sel", 32'(sel_idx_o), 32'h24);
        check_output("rst_mode", 32'(mode_o), 32'(TMR));
        check_output("rst_stall", 32'(stall_o), 32'd0);
        check_output("rst_fault", 32'(perm_faulty_o), 32'h0);
        check_output("rst_td", 32'(totally_defective_o), 32'd0);
        unit_used_i = 1'b0;
        #1;
        check_output("rst_gate_unused", 32'(clock_gate_o), 32'h0);
        unit_used_i = 1'b1;
        rst_n       = 1'b1;

        // Replica 1 faults; drain held by a busy pipeline.
        ex_idle_i = 1'b0;
        apply_stimulus(4'b0010, 7);
        check_output("r1_pre_thresh", 32'(perm_faulty_o), 32'h0);
        apply_stimulus(4'b0010, 1);
        check_output("r1_fault", 32'(perm_faulty_o), 32'h2);
        check_output("r1_no_stall_yet", 32'(stall_o), 32'd0);
        step();
        check_output("r1_drain", 32'(stall_o), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            check_output("r1_drain_hold", 32'(stall_o), 32'd1);
        end
        check_output("r1_sel_held", 32'(sel_idx_o), 32'h24);
        ex_idle_i = 1'b1;
        step();
        check_output("r1_switch", 32'(stall_o), 32'd1);
        check_output("r1_sel_old", 32'(sel_idx_o), 32'h24);
        step();
        check_output("r1_run", 32'(stall_o), 32'd0);
        check_output("r1_sel", 32'(sel_idx_o), 32'h38);
        check_output("r1_gate", 32'(clock_gate_o), 32'hD);
        check_output("r1_mode", 32'(mode_o), 32'(TMR));

        // Clear beats a simultaneous error and restores the reset configuration.
        apply_stimulus(4'b0100, 3);
        clear_i      = 1'b1;
        vote_valid_i = 1'b1;
        vote_err_i   = 4'b0100;
        step();
        clear_i      = 1'b0;
        vote_valid_i = 1'b0;
        vote_err_i   = 4'b0000;
        check_output("clr_fault", 32'(perm_faulty_o), 32'h0);
        run_reconfig("clr");
        check_output("clr_sel", 32'(sel_idx_o), 32'h24);
        check_output("clr_gate", 32'(clock_gate_o), 32'h7);
        apply_stimulus(4'b0100, 7);
        check_output("clr_cnt_zeroed", 32'(perm_faulty_o), 32'h0);
        apply_stimulus(4'b0100, 1);
        check_output("r2_fault", 32'(perm_faulty_o), 32'h4);
        run_reconfig("r2");
        check_output("r2_sel", 32'(sel_idx_o), 32'h34);
        check_output("r2_gate", 32'(clock_gate_o), 32'hB);

        // Two further faults, the second during DRAIN, share one SWITCH.
        ex_idle_i = 1'b0;
        apply_stimulus(4'b0001, 8);
        check_output("r0_fault", 32'(perm_faulty_o), 32'h5);
        step();
        check_output("r0_drain", 32'(stall_o), 32'd1);
        apply_stimulus(4'b1000, 8);
        check_output("r3_in_drain_fault", 32'(perm_faulty_o), 32'hD);
        check_output("r3_in_drain_stall", 32'(stall_o), 32'd1);
        ex_idle_i = 1'b1;
        step();
        check_output("dd_switch", 32'(stall_o), 32'd1);
        step();
        check_output("dd_run", 32'(stall_o), 32'd0);
        check_output("dd_mode", 32'(mode_o), 32'(SIMPLEX));
        check_output("dd_sel", 32'(sel_idx_o), 32'h15);
        check_output("dd_gate", 32'(clock_gate_o), 32'h2);
        step();
        check_output("dd_single_switch", 32'(stall_o), 32'd0);

        // Fault landing in the SWITCH cycle forces exactly one more round.
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        run_reconfig("clr2");
        check_output("clr2_sel", 32'(sel_idx_o), 32'h24);
        apply_stimulus(4'b0001, 7);
        apply_stimulus(4'b0010, 8);
        check_output("sw_first_fault", 32'(perm_faulty_o), 32'h2);
        step();
        check_output("sw_drain", 32'(stall_o), 32'd1);
        step();
        check_output("sw_switch", 32'(stall_o), 32'd1);
        apply_stimulus(4'b0001, 1);
        check_output("sw_run_stall", 32'(stall_o), 32'd0);
        check_output("sw_run_sel", 32'(sel_idx_o), 32'h38);
        check_output("sw_second_fault", 32'(perm_faulty_o), 32'h3);
        run_reconfig("sw2");
        check_output("sw2_mode", 32'(mode_o), 32'(DMR));
        check_output("sw2_sel", 32'(sel_idx_o), 32'h3E);
        check_output("sw2_gate", 32'(clock_gate_o), 32'hC);
        step();
        check_output("sw2_no_third", 32'(stall_o), 32'd0);

        // Degrade through SIMPLEX to NONE.
        apply_stimulus(4'b0100, 8);
        run_reconfig("smp");
        check_output("smp_mode", 32'(mode_o), 32'(SIMPLEX));
        check_output("smp_sel", 32'(sel_idx_o), 32'h3F);
        check_output("smp_gate", 32'(clock_gate_o), 32'h8);
        check_output("smp_td", 32'(totally_defective_o), 32'd0);
        apply_stimulus(4'b1000, 8);
        check_output("none_fault", 32'(perm_faulty_o), 32'hF);
        check_output("none_td", 32'(totally_defective_o), 32'd1);
        run_reconfig("none");
        check_output("none_mode", 32'(mode_o), 32'(NONE));
        check_output("none_sel", 32'(sel_idx_o), 32'h0);
        check_output("none_gate", 32'(clock_gate_o), 32'h0);
        step();
        check_output("none_not_stalled", 32'(stall_o), 32'd0);

        // Decay every 4 clean votes: 5 errors minus 2 decrements leaves 3.
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        check_output("clr3_td", 32'(totally_defective_o), 32'd0);
        run_reconfig("clr3");
        check_output("clr3_sel", 32'(sel_idx_o), 32'h24);
        apply_stimulus(4'b0010, 5);
        apply_stimulus(4'b0000, 8);
        apply_stimulus(4'b0010, 4);
        check_output("decay_no_fault", 32'(perm_faulty_o), 32'h0);
        apply_stimulus(4'b0010, 1);
        check_output("decay_fault", 32'(perm_faulty_o), 32'h2);

        // Reset in the middle of DRAIN drops the fault map.
        ex_idle_i = 1'b0;
        step();
        check_output("mid_drain", 32'(stall_o), 32'd1);
        rst_n = 1'b0;
        step();
        check_output("mid_rst_fault", 32'(perm_faulty_o), 32'h0);
        check_output("mid_rst_stall", 32'(stall_o), 32'd0);
        check_output("mid_rst_sel", 32'(sel_idx_o), 32'h24);
        check_output("mid_rst_gate", 32'(clock_gate_o), 32'h7);
        rst_n = 1'b1;
        step();
        check_output("post_rst_stall", 32'(stall_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
